// File: rtl/host_axi_pkg.sv
// Shared host-memory AXI4 read-channel types and constants.
// Used by the read arbiter, its order FIFO users and the channel interface.
package host_axi_pkg;

  localparam int unsigned HOST_ADDR_WIDTH = 48;
  localparam int unsigned HOST_DATA_WIDTH = 512;
  localparam int unsigned AXI_LEN_WIDTH   = 8;

  typedef struct packed {
    logic [HOST_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]   len;
    logic [2:0]                 size;
  } axi_ar_t;

  typedef struct packed {
    logic [HOST_DATA_WIDTH-1:0] data;
    logic [1:0]                 resp;
    logic                       last;
  } axi_r_t;

  typedef enum logic {
    StIdle,
    StIssue
  } ar_state_e;

  // Round-robin pick between two requesters: the preferred port wins if valid.
  function automatic logic rr_pick(logic rr, logic v0, logic v1);
    if (rr) begin
      return v1 ? 1'b1 : 1'b0;
    end
    return v0 ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/host_axi_rd_arbiter_if.sv
// AXI4 read channel (AR + R) bundle. "master" issues AR and sinks R,
// "slave" accepts AR and sources R.
interface host_axi_rd_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = host_axi_pkg::HOST_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = host_axi_pkg::HOST_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = host_axi_pkg::AXI_LEN_WIDTH
);

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic [2:0]            arsize;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/rd_order_fifo.sv
// Single-clock FIFO of grant indices; records which requester owns each
// outstanding burst so in-order responses can be routed back.
module rd_order_fifo #(
  parameter  int unsigned Depth    = 16,
  parameter  int unsigned Width    = 1,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CntWidth = PtrWidth + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [Width-1:0]    din,
  output logic [Width-1:0]    dout,
  output logic                empty,
  output logic                full,
  output logic [CntWidth-1:0] count
);

  logic [Width-1:0]    mem_q [Depth];
  logic [Width-1:0]    mem_d [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntWidth'(Depth));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntWidth'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/host_axi_rd_arbiter.sv
// Two-requester round-robin arbiter onto the single-ID host read channel.
// Responses return in order; an order FIFO of grant indices steers R beats.
module host_axi_rd_arbiter
  import host_axi_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH      = HOST_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH      = HOST_DATA_WIDTH,
  parameter  int unsigned LEN_WIDTH       = AXI_LEN_WIDTH,
  parameter  int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned CntWidth        = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                bcd_clk,
  input  logic                bcd_reset,
  host_axi_rd_arbiter_if.slave  s0,
  host_axi_rd_arbiter_if.slave  s1,
  host_axi_rd_arbiter_if.master m,
  output logic [CntWidth-1:0] outstanding,
  output logic                err_unexpected_r
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
  } ar_t;

  ar_state_e state_q, state_d;
  ar_t       ar_q, ar_d;
  logic      rr_q, rr_d;
  logic      err_q, err_d;
  logic      win;

  logic                fifo_push, fifo_pop;
  logic                fifo_dout, fifo_empty, fifo_full;
  logic [CntWidth-1:0] fifo_count;

  logic                  head_rready;
  logic                  m_rready_int;
  logic [DATA_WIDTH-1:0] rdata_bcast;

  rd_order_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (1)
  ) u_order_fifo (
    .clk   (bcd_clk),
    .rst   (bcd_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (win),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // AR arbitration. Full uses the registered count, so a same-cycle pop
  // only frees a slot on the following cycle.
  always_comb begin
    state_d    = state_q;
    ar_d       = ar_q;
    rr_d       = rr_q;
    fifo_push  = 1'b0;
    s0.arready = 1'b0;
    s1.arready = 1'b0;
    win        = rr_pick(rr_q, s0.arvalid, s1.arvalid);
    unique case (state_q)
      StIdle: begin
        if (!bcd_reset && (s0.arvalid || s1.arvalid) && !fifo_full) begin
          fifo_push = 1'b1;
          rr_d      = ~win;
          state_d   = StIssue;
          if (win) begin
            s1.arready = 1'b1;
            ar_d       = '{addr: s1.araddr, len: s1.arlen, size: s1.arsize};
          end else begin
            s0.arready = 1'b1;
            ar_d       = '{addr: s0.araddr, len: s0.arlen, size: s0.arsize};
          end
        end
      end
      StIssue: begin
        if (m.arready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign m.arvalid = (state_q == StIssue);
  assign m.araddr  = ar_q.addr;
  assign m.arlen   = ar_q.len;
  assign m.arsize  = ar_q.size;

  // R routing: only rvalid is steered, payload is broadcast.
  assign head_rready  = fifo_dout ? s1.rready : s0.rready;
  assign m_rready_int = ~fifo_empty & head_rready;
  assign m.rready     = m_rready_int;
  assign s0.rvalid    = m.rvalid & ~fifo_empty & ~fifo_dout;
  assign s1.rvalid    = m.rvalid & ~fifo_empty & fifo_dout;
  assign fifo_pop     = m.rvalid & m_rready_int & m.rlast;

  assign rdata_bcast = m.rdata;
  assign s0.rdata    = rdata_bcast;
  assign s1.rdata    = rdata_bcast;
  assign s0.rresp    = m.rresp;
  assign s1.rresp    = m.rresp;
  assign s0.rlast    = m.rlast;
  assign s1.rlast    = m.rlast;

  always_comb begin
    err_d = err_q | (m.rvalid & fifo_empty);
  end

  assign outstanding      = fifo_count;
  assign err_unexpected_r = err_q;

  always_ff @(posedge bcd_clk) begin
    if (bcd_reset) begin
      state_q <= StIdle;
      ar_q    <= '0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_host_axi_rd_arbiter.sv
// Directed self-checking bench for host_axi_rd_arbiter: one task per scenario.
module tb_host_axi_rd_arbiter;

  localparam int unsigned DW = 512;

  logic       clk;
  logic       rst;
  logic [4:0] outstanding;
  logic       err_r;
  int         n_cmp;
  int         n_fail;

  host_axi_rd_arbiter_if s0_if ();
  host_axi_rd_arbiter_if s1_if ();
  host_axi_rd_arbiter_if m_if ();

  host_axi_rd_arbiter dut (
    .bcd_clk          (clk),
    .bcd_reset        (rst),
    .s0               (s0_if.slave),
    .s1               (s1_if.slave),
    .m                (m_if.master),
    .outstanding      (outstanding),
    .err_unexpected_r (err_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    s0_if.arvalid = 0; s0_if.araddr = '0; s0_if.arlen = '0; s0_if.arsize = '0; s0_if.rready = 0;
    s1_if.arvalid = 0; s1_if.araddr = '0; s1_if.arlen = '0; s1_if.arsize = '0; s1_if.rready = 0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s0_if.arvalid = 1'b1;
    #2;
    n_cmp++;
    if (s0_if.arready !== 1'b0) begin
      n_fail++; $display("FAIL reset_arready: got %b exp 0", s0_if.arready);
    end
    step();
    s0_if.arvalid = 1'b0;
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({m_if.arvalid, m_if.araddr, m_if.arlen, outstanding, err_r} !== {1'b0, 48'h0, 8'h0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: arvalid=%b araddr=%h arlen=%h out=%0d err=%b exp all 0",
               m_if.arvalid, m_if.araddr, m_if.arlen, outstanding, err_r);
    end
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d;
    s0_if.arvalid = 1'b1; s0_if.araddr = 48'h1000; s0_if.arlen = 8'd3; s0_if.arsize = 3'd6;
    #2;
    n_cmp++;
    if ({s0_if.arready, s1_if.arready} !== 2'b10) begin
      n_fail++; $display("FAIL single_grant: got %b exp 10", {s0_if.arready, s1_if.arready});
    end
    step();
    s0_if.arvalid = 1'b0;
    #2;
    n_cmp++;
    if ({m_if.arvalid, m_if.araddr, m_if.arlen, m_if.arsize, outstanding} !== {1'b1, 48'h1000, 8'd3, 3'd6, 5'd1}) begin
      n_fail++;
      $display("FAIL single_issue: arvalid=%b addr=%h len=%0d size=%0d out=%0d exp 1 1000 3 6 1",
               m_if.arvalid, m_if.araddr, m_if.arlen, m_if.arsize, outstanding);
    end
    m_if.arready = 1'b1;
    step();
    m_if.arready = 1'b0;
    s0_if.rready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      m_if.rvalid = 1'b1; m_if.rdata = DW'(32'h500 + j); m_if.rlast = (j == 3);
      exp_d = DW'(32'h500 + j);
      #2;
      n_cmp++;
      if ({s0_if.rvalid, s1_if.rvalid, m_if.rready, s0_if.rlast} !== {3'b101, (j == 3)} ||
          s0_if.rdata !== exp_d) begin
        n_fail++;
        $display("FAIL single_beat%0d: rv0=%b rv1=%b rready=%b last=%b data=%h exp 1 0 1 %b %h",
                 j, s0_if.rvalid, s1_if.rvalid, m_if.rready, s0_if.rlast, s0_if.rdata[31:0],
                 (j == 3), exp_d[31:0]);
      end
      step();
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #2;
    n_cmp++;
    if (outstanding !== 5'd0) begin
      n_fail++; $display("FAIL single_drained: out=%0d exp 0", outstanding);
    end
    step();
  endtask

  task automatic test_contention();
    int grants[$];
    s0_if.arvalid = 1'b1; s0_if.araddr = 48'h2000; s0_if.arlen = 8'd0;
    s1_if.arvalid = 1'b1; s1_if.araddr = 48'h3000; s1_if.arlen = 8'd0;
    m_if.arready = 1'b1;
    for (int c = 0; c < 80 && grants.size() < 16; c++) begin
      #2;
      if (s0_if.arready && s1_if.arready) grants.push_back(9);
      else if (s0_if.arready) grants.push_back(0);
      else if (s1_if.arready) grants.push_back(1);
      step();
    end
    n_cmp++;
    if (grants.size() != 16) begin
      n_fail++; $display("FAIL contention_count: got %0d grants exp 16", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      n_cmp++;
      if (grants[i] != i % 2) begin
        n_fail++; $display("FAIL contention_order%0d: got %0d exp %0d", i, grants[i], i % 2);
      end
    end
  endtask

  task automatic test_full();
    for (int c = 0; c < 5; c++) begin
      #2;
      n_cmp++;
      if ({s0_if.arready, s1_if.arready, outstanding} !== {2'b00, 5'd16}) begin
        n_fail++;
        $display("FAIL full_c%0d: arready=%b%b out=%0d exp 00 16",
                 c, s0_if.arready, s1_if.arready, outstanding);
      end
      step();
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp_d;
    logic          exp_p;
    s0_if.rready = 1'b1; s1_if.rready = 1'b1;
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rdata = DW'(32'h0);
    #2;
    n_cmp++;
    if ({s0_if.rvalid, m_if.rready, s0_if.arready, s1_if.arready} !== 4'b1100) begin
      n_fail++;
      $display("FAIL drain_pop_cycle: rv0=%b rready=%b arready=%b%b exp 1 1 00",
               s0_if.rvalid, m_if.rready, s0_if.arready, s1_if.arready);
    end
    step();
    m_if.rvalid = 1'b0;
    #2;
    n_cmp++;
    if ({s0_if.arready, s1_if.arready, outstanding} !== {2'b10, 5'd15}) begin
      n_fail++;
      $display("FAIL drain_next_grant: arready=%b%b out=%0d exp 10 15",
               s0_if.arready, s1_if.arready, outstanding);
    end
    step();
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rdata = DW'(32'h100 + j);
      exp_d = DW'(32'h100 + j);
      exp_p = ((j + 1) % 2) == 1;
      #2;
      n_cmp++;
      if ({s0_if.rvalid, s1_if.rvalid} !== {~exp_p, exp_p} || s0_if.rdata !== exp_d ||
          s1_if.rdata !== exp_d) begin
        n_fail++;
        $display("FAIL drain_route%0d: rv=%b%b data=%h exp rv=%b%b data=%h", j, s0_if.rvalid,
                 s1_if.rvalid, s0_if.rdata[31:0], ~exp_p, exp_p, exp_d[31:0]);
      end
      step();
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; m_if.arready = 1'b0;
    #2;
    n_cmp++;
    if (outstanding !== 5'd0) begin
      n_fail++; $display("FAIL drain_empty: out=%0d exp 0", outstanding);
    end
    step();
  endtask

  task automatic test_ar_backpressure();
    s1_if.arvalid = 1'b1; s1_if.araddr = 48'h3000; s1_if.arlen = 8'd5; s1_if.arsize = 3'd6;
    m_if.arready = 1'b0;
    #2;
    n_cmp++;
    if ({s0_if.arready, s1_if.arready} !== 2'b01) begin
      n_fail++; $display("FAIL arbp_grant: got %b%b exp 01", s0_if.arready, s1_if.arready);
    end
    step();
    s1_if.arvalid = 1'b0;
    s0_if.arvalid = 1'b1; s0_if.araddr = 48'h4000; s0_if.arlen = 8'd0;
    for (int c = 0; c < 10; c++) begin
      #2;
      n_cmp++;
      if ({m_if.arvalid, m_if.araddr, m_if.arlen, s0_if.arready, s1_if.arready} !==
          {1'b1, 48'h3000, 8'd5, 2'b00}) begin
        n_fail++;
        $display("FAIL arbp_hold%0d: arvalid=%b addr=%h len=%0d arready=%b%b exp 1 3000 5 00",
                 c, m_if.arvalid, m_if.araddr, m_if.arlen, s0_if.arready, s1_if.arready);
      end
      step();
    end
    m_if.arready = 1'b1;
    step();
    m_if.arready = 1'b0;
    #2;
    n_cmp++;
    if ({m_if.arvalid, s0_if.arready} !== 2'b01) begin
      n_fail++; $display("FAIL arbp_release: arvalid=%b arready0=%b exp 0 1", m_if.arvalid, s0_if.arready);
    end
    step();
    s0_if.arvalid = 1'b0;
    m_if.arready = 1'b1;
    #2;
    n_cmp++;
    if ({m_if.arvalid, m_if.araddr, m_if.arlen} !== {1'b1, 48'h4000, 8'd0}) begin
      n_fail++;
      $display("FAIL arbp_second: arvalid=%b addr=%h len=%0d exp 1 4000 0",
               m_if.arvalid, m_if.araddr, m_if.arlen);
    end
    step();
    m_if.arready = 1'b0;
  endtask

  task automatic test_r_backpressure();
    logic [DW-1:0] exp_d;
    s0_if.rready = 1'b1; s1_if.rready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = DW'(32'hA0); m_if.rlast = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++;
      if ({m_if.rready, s1_if.rvalid, s0_if.rvalid, outstanding} !== {3'b010, 5'd2}) begin
        n_fail++;
        $display("FAIL rbp_stall%0d: rready=%b rv1=%b rv0=%b out=%0d exp 0 1 0 2",
                 c, m_if.rready, s1_if.rvalid, s0_if.rvalid, outstanding);
      end
      step();
    end
    s1_if.rready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      m_if.rdata = DW'(32'hA0 + j); m_if.rlast = (j == 5);
      exp_d = DW'(32'hA0 + j);
      #2;
      n_cmp++;
      if ({m_if.rready, s1_if.rvalid, s0_if.rvalid} !== 3'b110 || s1_if.rdata !== exp_d) begin
        n_fail++;
        $display("FAIL rbp_beat%0d: rready=%b rv1=%b rv0=%b data=%h exp 1 1 0 %h", j,
                 m_if.rready, s1_if.rvalid, s0_if.rvalid, s1_if.rdata[31:0], exp_d[31:0]);
      end
      step();
    end
    m_if.rdata = DW'(32'hB0); m_if.rlast = 1'b1;
    #2;
    n_cmp++;
    if ({s0_if.rvalid, s1_if.rvalid, m_if.rready} !== 3'b101) begin
      n_fail++;
      $display("FAIL rbp_s0_beat: rv0=%b rv1=%b rready=%b exp 1 0 1",
               s0_if.rvalid, s1_if.rvalid, m_if.rready);
    end
    step();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #2;
    n_cmp++;
    if (outstanding !== 5'd0) begin
      n_fail++; $display("FAIL rbp_empty: out=%0d exp 0", outstanding);
    end
    step();
  endtask

  task automatic test_unexpected_r();
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
    #2;
    n_cmp++;
    if ({m_if.rready, s0_if.rvalid, s1_if.rvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL unexp_stall: rready=%b rv=%b%b exp 0 00",
               m_if.rready, s0_if.rvalid, s1_if.rvalid);
    end
    step();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #2;
    n_cmp++;
    if (err_r !== 1'b1) begin
      n_fail++; $display("FAIL unexp_set: err=%b exp 1", err_r);
    end
    for (int c = 0; c < 5; c++) step();
    #2;
    n_cmp++;
    if (err_r !== 1'b1) begin
      n_fail++; $display("FAIL unexp_sticky: err=%b exp 1", err_r);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    // Three port-0 bursts leave the rr pointer on port 1 before the reset.
    s0_if.arvalid = 1'b1; s0_if.araddr = 48'h5000; s0_if.arlen = 8'd2;
    m_if.arready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    s0_if.arvalid = 1'b0;
    m_if.arready = 1'b0;
    #2;
    n_cmp++;
    if ({m_if.arvalid, outstanding} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL midrst_pre: arvalid=%b out=%0d exp 1 3", m_if.arvalid, outstanding);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({m_if.arvalid, outstanding, err_r} !== {1'b0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_state: arvalid=%b out=%0d err=%b exp 0 0 0",
               m_if.arvalid, outstanding, err_r);
    end
    s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
    #1;
    n_cmp++;
    if ({s0_if.arready, s1_if.arready} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_rr: arready=%b%b exp 10", s0_if.arready, s1_if.arready);
    end
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    apply_reset();
    test_reset();
    test_single();
    apply_reset();
    test_contention();
    test_full();
    test_drain();
    test_ar_backpressure();
    test_r_backpressure();
    test_unexpected_r();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
